// File: rtl/dbus_sram_responder_pkg.sv
// Shared data-bus types for the core and its memory-side responders.
//   u64 / u8          : plain word and byte types
//   msize_t           : access size carried on the bus (not interpreted by the SRAM)
//   dbus_req_t        : MEM-stage request {valid, addr, size, strobe, data}
//   dbus_resp_t       : responder reply {addr_ok, data_ok, data}
//   dresp_state_t     : SRAM responder FSM states
//   DBUS_WORD_BYTES   : bytes per bus word
package dbus_sram_responder_pkg;

    typedef logic [63:0] u64;
    typedef logic [7:0]  u8;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic   valid;
        u64     addr;
        msize_t size;
        u8      strobe;
        u64     data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    typedef enum logic [1:0] {
        DR_IDLE,
        DR_BUSY,
        DR_RESP
    } dresp_state_t;

    localparam int DBUS_WORD_BYTES = 8;

endpackage

// File: rtl/dbus_mem_array.sv
// DEPTH x 64-bit word storage behind the data-bus responder.
//   clk    : clock, rising edge
//   we     : write enable (one word per cycle)
//   waddr  : word index written when we=1
//   wstrb  : byte enables for the write, bit i covers data byte i
//   wdata  : write data
//   raddr  : word index for the combinational read port
//   rdata  : mem[raddr], reflects writes from the previous edge onward
// Contents are deliberately not reset.
module dbus_mem_array
    import dbus_sram_responder_pkg::*;
#(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
)(
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  u8             wstrb,
    input  u64            wdata,
    input  logic [AW-1:0] raddr,
    output u64            rdata
);

    u64 mem [DEPTH];

    assign rdata = mem[raddr];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DBUS_WORD_BYTES; b++) begin
                if (wstrb[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dbus_sram_responder.sv
// Memory-side responder for the core data bus, backed by a word-organised
// 64-bit SRAM with a fixed response latency and byte-strobe writes.
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset (control state and rdata_q only)
//   dreq     : request from the MEM stage; held stable until data_ok is seen
//   dresp    : addr_ok/data_ok pulse together for one cycle per transaction;
//              data carries the word read at RESP entry (pre-write for writes)
// Parameters:
//   DEPTH    : number of 64-bit words, power of two
//   BASE     : byte address that maps to word 0; other addresses wrap mod DEPTH
//   LATENCY  : cycles from acceptance to data_ok, 1..15
module dbus_sram_responder
    import dbus_sram_responder_pkg::*;
#(
    parameter int          DEPTH   = 1024,
    parameter logic [63:0] BASE    = 64'h8000_0000,
    parameter int          LATENCY = 2
)(
    input  logic       clk,
    input  logic       reset_n,
    input  dbus_req_t  dreq,
    output dbus_resp_t dresp
);

    localparam int AW = $clog2(DEPTH);
    // BUSY counts down from LATENCY-2 so that RESP lands LATENCY cycles after acceptance.
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    dresp_state_t  state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;

    u64            off;
    logic [AW-1:0] req_idx;
    logic [AW-1:0] rd_idx;
    u64            rd_word;

    logic [AW-1:0] idx_q;
    u8             strobe_q;
    u64            wdata_q;
    u64            rdata_q;

    logic          resp_fire;
    logic          mem_we;
    logic          unused_bits;

    // Word index: offset from BASE in 8-byte units, wrapped to the array size.
    assign off     = dreq.addr - BASE;
    assign req_idx = off[AW+2:3];

    // Byte offset within the word, high offset bits and size play no part in addressing.
    assign unused_bits = ^{off[63:AW+3], off[2:0], dreq.size};

    // In IDLE the live request addresses the array so that LATENCY==1 can
    // capture read data on the accepting edge; afterwards the latched index is used.
    assign rd_idx = (state == DR_IDLE) ? req_idx : idx_q;

    // Response only while the initiator still holds valid in RESP.
    assign resp_fire = (state == DR_RESP) && dreq.valid;
    assign mem_we    = resp_fire && (strobe_q != 8'd0);

    dbus_mem_array #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (idx_q),
        .wstrb (strobe_q),
        .wdata (wdata_q),
        .raddr (rd_idx),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DR_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            DR_IDLE: begin
                if (dreq.valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = DR_RESP;
                    end else begin
                        state_nxt = DR_BUSY;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            DR_BUSY: begin
                if (!dreq.valid) begin
                    state_nxt = DR_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt = DR_RESP;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DR_RESP: begin
                state_nxt = DR_IDLE;
            end
            default: begin
                state_nxt = DR_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Read data is sampled on the edge entering RESP, before any write in RESP commits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (state_nxt == DR_RESP) begin
            rdata_q <= rd_word;
        end
    end

    // Request latch; later changes to the bus fields are ignored.
    always_ff @(posedge clk) begin
        if ((state == DR_IDLE) && dreq.valid) begin
            idx_q    <= req_idx;
            strobe_q <= dreq.strobe;
            wdata_q  <= dreq.data;
        end
    end

    always_comb begin
        dresp         = '0;
        dresp.addr_ok = resp_fire;
        dresp.data_ok = resp_fire;
        dresp.data    = resp_fire ? rdata_q : 64'd0;
    end

endmodule

// File: tb/tb_dbus_sram_responder.sv
`timescale 1ns/1ps
module tb_dbus_sram_responder;
    import dbus_sram_responder_pkg::*;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          DEPTH = 1024;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    dbus_req_t  req  [2];
    dbus_resp_t resp [2];
    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [63:0] data;
        bit          chk;
        int          cyc;
    } exp_t;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] mdl   [2][DEPTH];
    bit          known [2][DEPTH];

    // Instance 0 runs with LATENCY=2, instance 1 with LATENCY=1.
    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(2)) dut_l2 (
        .clk(clk), .reset_n(reset_n), .dreq(req[0]), .dresp(resp[0])
    );
    dbus_sram_responder #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(1)) dut_l1 (
        .clk(clk), .reset_n(reset_n), .dreq(req[1]), .dresp(resp[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int idx_of(input logic [63:0] a);
        logic [63:0] o;
        o = a - BASE;
        return int'((o / 64'd8) % 64'(DEPTH));
    endfunction

    function automatic logic [63:0] addr_of(input int i, input int alias_n, input int lo);
        return BASE + 64'(8 * i) + 64'(8 * DEPTH * alias_n) + 64'(lo);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, expv, $time);
        end
    endtask

    task automatic mon(input int k);
        exp_t  e;
        int    qs;
        string tag;
        tag = (k == 0) ? "L2" : "L1";
        chk({tag, "_ok_pair"}, 64'(resp[k].addr_ok), 64'(resp[k].data_ok));
        if (!resp[k].data_ok) begin
            chk({tag, "_idle_data"}, resp[k].data, 64'h0);
        end else begin
            qs = (k == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_unexpected_resp data_ok=1 expected=none cyc=%0d", tag, cyc);
            end else begin
                if (k == 0) e = q0.pop_front();
                else        e = q1.pop_front();
                chk({tag, "_resp_cycle"}, 64'(cyc), 64'(e.cyc));
                if (e.chk) chk({tag, "_resp_data"}, resp[k].data, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic drive(input int k, input bit v, input logic [63:0] a,
                         input logic [7:0] s, input logic [63:0] d);
        req[k].valid  = v;
        req[k].addr   = a;
        req[k].size   = MSIZE8;
        req[k].strobe = s;
        req[k].data   = d;
    endtask

    task automatic scramble(input int k);
        req[k].addr   = {$urandom, $urandom};
        req[k].strobe = 8'($urandom);
        req[k].data   = {$urandom, $urandom};
    endtask

    task automatic idle(input int k, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            req[k].valid = 1'b0;
            scramble(k);
        end
    endtask

    // Issue one transaction, push its expected response, and wait for data_ok.
    // Valid stays high on return so a following txn is a back-to-back request.
    task automatic txn(input int k, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
        exp_t e;
        int   i;
        int   n;
        @(posedge clk); #1;
        drive(k, 1'b1, a, s, d);
        i     = idx_of(a);
        e.cyc = cyc + lat_of(k);
        e.data = mdl[k][i];
        e.chk  = known[k][i];
        if (k == 0) q0.push_back(e);
        else        q1.push_back(e);
        if (s != 8'h00) begin
            for (int b = 0; b < 8; b++) begin
                if (s[b]) mdl[k][i][8*b +: 8] = d[8*b +: 8];
            end
            if (s == 8'hFF) known[k][i] = 1'b1;
        end
        n = 0;
        forever begin
            @(negedge clk);
            if (resp[k].data_ok) break;
            n++;
            if (n > 40) begin
                checks++;
                errors++;
                $display("FAIL txn_timeout inst=%0d data_ok=0 expected=1", k);
                break;
            end
            @(posedge clk); #1;
            scramble(k);
        end
    endtask

    // Request held for 'hold' cycles then withdrawn before data_ok: no response, no write.
    task automatic abort_txn(input int k, input logic [63:0] a, input logic [7:0] s,
                             input logic [63:0] d, input int hold);
        @(posedge clk); #1;
        drive(k, 1'b1, a, s, d);
        repeat (hold - 1) begin
            @(posedge clk); #1;
            scramble(k);
        end
        @(posedge clk); #1;
        req[k].valid = 1'b0;
        idle(k, 2);
    endtask

    initial begin
        int          prev;
        int          r;
        logic [63:0] a;
        logic [7:0]  s;

        drive(0, 1'b0, 64'h0, 8'h0, 64'h0);
        drive(1, 1'b0, 64'h0, 8'h0, 64'h0);
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < DEPTH; i++) begin
                mdl[k][i]   = 64'h0;
                known[k][i] = 1'b0;
            end
        end
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Give the words used below a known value.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 16; i++) txn(k, addr_of(i, 0, 0), 8'hFF, {$urandom, $urandom});
            idle(k, 1);
        end

        // Reset held 3 cycles with a write pending on the bus.
        @(posedge clk); #1;
        drive(0, 1'b1, addr_of(1, 0, 0), 8'hFF, 64'hDEAD_BEEF_0BAD_F00D);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_ok_flags", {62'h0, resp[0].addr_ok, resp[0].data_ok}, 64'h0);
            chk("rst_data", resp[0].data, 64'h0);
        end
        @(posedge clk); #1;
        req[0].valid = 1'b0;
        reset_n = 1'b1;
        txn(0, addr_of(1, 0, 0), 8'h00, 64'h0);
        idle(0, 1);

        // Full write then read back.
        txn(0, BASE + 64'd8, 8'hFF, 64'h1122_3344_5566_7788);
        txn(0, BASE + 64'd8, 8'h00, 64'h0);
        chk("t2_read", resp[0].data, 64'h1122_3344_5566_7788);
        idle(0, 1);

        // Partial write over an all-ones word.
        txn(0, BASE + 64'd24, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        txn(0, BASE + 64'd24, 8'h0F, 64'h0);
        chk("t3_write_prev", resp[0].data, 64'hFFFF_FFFF_FFFF_FFFF);
        txn(0, BASE + 64'd24, 8'h00, 64'h0);
        chk("t3_read", resp[0].data, 64'hFFFF_FFFF_0000_0000);
        idle(0, 1);

        // Withdrawn writes: dropped in BUSY, then dropped in RESP.
        abort_txn(0, BASE + 64'd16, 8'hFF, 64'h5555_AAAA_5555_AAAA, 1);
        txn(0, BASE + 64'd16, 8'h00, 64'h0);
        idle(0, 1);
        abort_txn(0, BASE + 64'd16, 8'hFF, 64'h6666_9999_6666_9999, 2);
        txn(0, BASE + 64'd16, 8'h00, 64'h0);
        idle(0, 1);
        abort_txn(1, BASE + 64'd16, 8'hFF, 64'h7777_8888_7777_8888, 1);
        txn(1, BASE + 64'd16, 8'h00, 64'h0);
        idle(1, 1);

        // Address wrap and ignored byte offset.
        txn(0, BASE + 64'd8192, 8'hFF, 64'hCAFE_F00D_1234_5678);
        txn(0, BASE, 8'h00, 64'h0);
        chk("t6_wrap_read", resp[0].data, 64'hCAFE_F00D_1234_5678);
        txn(0, BASE + 64'd13, 8'h00, 64'h0);
        chk("t6_word1_read", resp[0].data, 64'h1122_3344_5566_7788);
        idle(0, 1);

        // Reset during BUSY loses the uncommitted write.
        @(posedge clk); #1;
        drive(0, 1'b1, addr_of(5, 0, 0), 8'hFF, 64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        reset_n = 1'b0;
        req[0].valid = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        txn(0, addr_of(5, 0, 0), 8'h00, 64'h0);
        idle(0, 1);

        // LATENCY=1 back-to-back reads with valid held throughout.
        txn(1, addr_of(0, 0, 0), 8'h00, 64'h0);
        prev = cyc;
        for (int j = 1; j < 6; j++) begin
            txn(1, addr_of(j, 0, 0), 8'h00, 64'h0);
            chk("t5_spacing", 64'(cyc - prev), 64'd2);
            prev = cyc;
        end
        idle(1, 1);

        // Randomised mix on both instances.
        for (int k = 0; k < 2; k++) begin
            for (int it = 0; it < 80; it++) begin
                r = $urandom_range(0, 99);
                a = addr_of($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 7));
                s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
                if (r < 15) abort_txn(k, a, s, {$urandom, $urandom}, $urandom_range(1, lat_of(k)));
                else        txn(k, a, s, {$urandom, $urandom});
                r = $urandom_range(0, 2);
                if (r != 0) idle(k, r);
            end
            idle(k, 1);
        end

        repeat (5) @(posedge clk);
        chk("queue_drained", 64'(q0.size() + q1.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
